// File: rtl/sot_align_sequencer.sv
// sot_align_sequencer
//    Walks the VFAT SOT frame aligners one channel at a time, round-robin.
//    For each queued channel the sequencer pulses its aligner reset, waits
//    (bounded by a timeout) for sot_is_aligned, retries a limited number of
//    times and finally records the channel as aligned or failed. Channels
//    whose aligner raises sot_unstable can be re-queued automatically.
//
// Ports
//    clock           40 MHz LHC clock, single domain
//    reset_n         asynchronous active-low reset
//    start           one-clock strobe: queue every unmasked channel
//    auto_realign    re-queue a channel on the rising edge of its sot_unstable
//    vfat_mask       1 = channel excluded from sequencing
//    sot_is_aligned  per-aligner ready flag
//    sot_unstable    per-aligner unstable flag
//    aligner_reset   per-aligner reset, registered, at most one bit high
//    busy            high whenever the sequencer is not idle
//    done            one-clock pulse when the queue drains
//    active_vfat     index of the channel being serviced (holds in idle)
//    aligned         channel passed its last alignment
//    failed          channel exhausted its retries
//    realign_cnt     saturating count of automatic re-queues
module sot_align_sequencer #(
   parameter int NVFAT        = 24,
   parameter int RESET_CYCLES = 8,
   parameter int TIMEOUT      = 8191,
   parameter int MAX_RETRIES  = 3,
   parameter int IDXW         = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             auto_realign,
   input  logic [NVFAT-1:0] vfat_mask,
   input  logic [NVFAT-1:0] sot_is_aligned,
   input  logic [NVFAT-1:0] sot_unstable,
   output logic [NVFAT-1:0] aligner_reset,
   output logic             busy,
   output logic             done,
   output logic [IDXW-1:0]  active_vfat,
   output logic [NVFAT-1:0] aligned,
   output logic [NVFAT-1:0] failed,
   output logic [15:0]      realign_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RESET, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t           state, next_state;
   logic [NVFAT-1:0] pending, pending_nxt, aligned_nxt, failed_nxt;
   logic [NVFAT-1:0] unstable_q, eligible, rise, active_onehot, sel_onehot;
   logic [IDXW-1:0]  ptr, sel_idx;
   logic             any_eligible, found;
   logic             cur_aligned, cur_masked, timeout_hit, reset_done, last_try;
   logic [3:0]       retry;
   logic [15:0]      timer;
   logic [7:0]       rst_cnt;
   logic [IDXW:0]    rise_cnt;
   logic [16:0]      cnt_sum;
   int               j;

   assign eligible      = pending & ~vfat_mask;
   assign any_eligible  = |eligible;
   assign active_onehot = {{(NVFAT-1){1'b0}}, 1'b1} << active_vfat;
   assign sel_onehot    = {{(NVFAT-1){1'b0}}, 1'b1} << sel_idx;
   assign cur_aligned   = sot_is_aligned[active_vfat];
   assign cur_masked    = vfat_mask[active_vfat];
   assign timeout_hit   = (timer == 16'(TIMEOUT - 1));
   assign reset_done    = (rst_cnt == 8'(RESET_CYCLES - 1));
   assign last_try      = (retry == 4'(MAX_RETRIES));

   // The channel in service cannot re-queue itself; its unstable edge is ignored.
   assign rise = sot_unstable & ~unstable_q & ~vfat_mask &
                 ~((state != S_IDLE) ? active_onehot : '0);

   // Round-robin pick: first eligible channel at or above ptr, wrapping to 0.
   always_comb begin
      sel_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NVFAT; k++) begin
         j = int'(ptr) + k;
         if (j >= NVFAT) j = j - NVFAT;
         if (!found && eligible[j]) begin
            found   = 1'b1;
            sel_idx = IDXW'(j);
         end
      end
   end

   // Several channels may go unstable on one clock; each counts as a re-queue.
   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < NVFAT; i++) rise_cnt = rise_cnt + {{IDXW{1'b0}}, rise[i]};
      cnt_sum = {1'b0, realign_cnt} + 17'(rise_cnt);
   end

   // Next-state logic. Masking the active channel abandons it at once;
   // success is checked before the timeout so a tie counts as aligned.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (any_eligible) next_state = S_SELECT;
         S_SELECT: next_state = any_eligible ? S_RESET : S_DONE;
         S_RESET: begin
            if (cur_masked)      next_state = S_NEXT;
            else if (reset_done) next_state = S_WAIT;
         end
         S_WAIT: begin
            if (cur_masked || cur_aligned) next_state = S_NEXT;
            else if (timeout_hit)          next_state = last_try ? S_NEXT : S_RESET;
         end
         S_NEXT:   next_state = any_eligible ? S_SELECT : S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Queue and status vectors. Start and unstable requests are merged first,
   // then the channel being picked is removed from the queue.
   always_comb begin
      pending_nxt = pending;
      aligned_nxt = aligned & ~rise;
      failed_nxt  = failed;
      if (start) begin
         pending_nxt = pending_nxt | ~vfat_mask;
         failed_nxt  = failed_nxt & vfat_mask;
      end
      if (auto_realign) pending_nxt = pending_nxt | rise;
      if (state == S_SELECT && any_eligible) begin
         pending_nxt = pending_nxt & ~sel_onehot;
         aligned_nxt = aligned_nxt & ~sel_onehot;
      end
      if (state == S_WAIT && !cur_masked) begin
         if (cur_aligned) begin
            aligned_nxt = aligned_nxt | active_onehot;
            failed_nxt  = failed_nxt & ~active_onehot;
         end else if (timeout_hit && last_try) begin
            failed_nxt  = failed_nxt | active_onehot;
         end
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Registered outputs, counters and the per-channel reset pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending       <= '0;
         aligned       <= '0;
         failed        <= '0;
         unstable_q    <= '0;
         aligner_reset <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         active_vfat   <= '0;
         ptr           <= '0;
         retry         <= '0;
         timer         <= '0;
         rst_cnt       <= '0;
         realign_cnt   <= '0;
      end else begin
         pending    <= pending_nxt;
         aligned    <= aligned_nxt;
         failed     <= failed_nxt;
         unstable_q <= sot_unstable;
         busy       <= (next_state != S_IDLE);
         done       <= (next_state == S_DONE);
         if (auto_realign && (rise_cnt != '0))
            realign_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
         case (state)
            S_SELECT: if (any_eligible) begin
               active_vfat   <= sel_idx;
               retry         <= '0;
               rst_cnt       <= '0;
               aligner_reset <= sel_onehot;
            end
            S_RESET: begin
               if (cur_masked) begin
                  aligner_reset <= '0;
               end else if (reset_done) begin
                  aligner_reset <= '0;
                  timer         <= '0;
               end else begin
                  rst_cnt <= rst_cnt + 8'd1;
               end
            end
            S_WAIT: begin
               timer <= timer + 16'd1;
               if (!cur_masked && !cur_aligned && timeout_hit && !last_try) begin
                  retry         <= retry + 4'd1;
                  rst_cnt       <= '0;
                  aligner_reset <= active_onehot;
               end
            end
            S_NEXT:
               ptr <= (active_vfat == IDXW'(NVFAT - 1)) ? '0 : active_vfat + IDXW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sot_align_sequencer.sv
// tb_sot_align_sequencer
//    Scoreboard bench for sot_align_sequencer. The stimulus process queues the
//    reset pulses and done snapshots each scenario should produce; a monitor
//    on the falling clock edge pops and compares whenever a pulse ends or done
//    fires. A small aligner model answers sot_is_aligned a programmable number
//    of clocks after its reset is released.
module tb_sot_align_sequencer;

   localparam int NVFAT = 24;
   localparam int RC    = 8;
   localparam int TO    = 100;
   localparam int MR    = 3;
   localparam int IDXW  = 5;

   typedef struct {
      int          kind;   // 0 = reset pulse, 1 = done
      int          ch;
      logic [23:0] al;
      logic [23:0] fl;
      logic [15:0] cnt;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              start;
   logic              auto_realign;
   logic [NVFAT-1:0]  vfat_mask;
   logic [NVFAT-1:0]  sot_is_aligned = '0;
   logic [NVFAT-1:0]  sot_unstable;
   logic [NVFAT-1:0]  aligner_reset;
   logic              busy;
   logic              done;
   logic [IDXW-1:0]   active_vfat;
   logic [NVFAT-1:0]  aligned;
   logic [NVFAT-1:0]  failed;
   logic [15:0]       realign_cnt;

   exp_t              sbq[$];
   int                compared   = 0;
   int                mismatched = 0;
   bit                sb_quiet   = 1'b0;
   int                lat   [NVFAT];
   logic [NVFAT-1:0]  never = '0;
   int                acnt  [NVFAT] = '{default: 0};
   logic [NVFAT-1:0]  armed = '0;
   logic [NVFAT-1:0]  prev_ar = '0;
   int                cur_len = 0;
   int                cur_ch  = 0;

   sot_align_sequencer #(
      .NVFAT(NVFAT), .RESET_CYCLES(RC), .TIMEOUT(TO), .MAX_RETRIES(MR), .IDXW(IDXW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .auto_realign(auto_realign),
      .vfat_mask(vfat_mask), .sot_is_aligned(sot_is_aligned), .sot_unstable(sot_unstable),
      .aligner_reset(aligner_reset), .busy(busy), .done(done), .active_vfat(active_vfat),
      .aligned(aligned), .failed(failed), .realign_cnt(realign_cnt)
   );

   always #5 clock = ~clock;

   // Aligner model: ready lat[i] clocks after reset release unless never[i].
   always @(posedge clock) begin
      #1;
      for (int i = 0; i < NVFAT; i++) begin
         if (aligner_reset[i]) begin
            acnt[i]  = 0;
            armed[i] = 1'b1;
         end else if (acnt[i] < 100000) begin
            acnt[i] = acnt[i] + 1;
         end
         sot_is_aligned[i] = armed[i] && !never[i] && (acnt[i] >= lat[i]);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_rst(input int ch);
      exp_t e;
      e.kind = 0; e.ch = ch; e.al = '0; e.fl = '0; e.cnt = '0;
      sbq.push_back(e);
   endtask

   task automatic expect_done(input logic [23:0] al, input logic [23:0] fl, input logic [15:0] cnt);
      exp_t e;
      e.kind = 1; e.ch = 0; e.al = al; e.fl = fl; e.cnt = cnt;
      sbq.push_back(e);
   endtask

   // Monitor: compares each finished reset pulse and each done pulse.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && !sb_quiet) begin
         if (prev_ar != '0 && aligner_reset != prev_ar) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_pulse_ch", 32'(cur_ch), 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               checkOutput("event_kind_pulse", 32'(0), 32'(e.kind));
               checkOutput("pulse_ch", 32'(cur_ch), 32'(e.ch));
               checkOutput("pulse_len", 32'(cur_len), 32'(RC));
            end
         end
         if (aligner_reset != '0) begin
            if (aligner_reset != prev_ar) begin
               cur_len = 1;
               for (int i = 0; i < NVFAT; i++) if (aligner_reset[i]) cur_ch = i;
            end else begin
               cur_len++;
            end
            if (!$onehot(aligner_reset)) checkOutput("reset_onehot", 32'(aligner_reset), 32'h0);
         end
         if (done) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_done", 32'(1), 32'(0));
            end else begin
               e = sbq.pop_front();
               checkOutput("event_kind_done", 32'(1), 32'(e.kind));
               checkOutput("done_aligned", 32'(aligned), 32'(e.al));
               checkOutput("done_failed", 32'(failed), 32'(e.fl));
               checkOutput("done_realign_cnt", 32'(realign_cnt), 32'(e.cnt));
            end
         end
      end
      prev_ar = aligner_reset;
   end

   // One-clock start strobe; returns on the falling edge after it was sampled.
   task automatic applyStimulus(input logic [23:0] mask, input logic aa);
      vfat_mask    = mask;
      auto_realign = aa;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string tag);
      int n = 0;
      while (!done && n < limit) begin
         @(negedge clock);
         n++;
      end
      if (!done) checkOutput({tag, "_done_timeout"}, 32'(n), 32'(limit - 1));
      @(negedge clock);
      checkOutput({tag, "_queue_drained"}, 32'(sbq.size()), 32'(0));
   endtask

   initial begin
      int n;
      for (int i = 0; i < NVFAT; i++) lat[i] = 20;
      reset_n      = 1'b0;
      start        = 1'b0;
      auto_realign = 1'b0;
      vfat_mask    = '0;
      sot_unstable = '0;
      repeat (3) @(negedge clock);
      checkOutput("rst_aligner_reset", 32'(aligner_reset), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_active", 32'(active_vfat), 32'h0);
      checkOutput("rst_aligned", 32'(aligned), 32'h0);
      checkOutput("rst_failed", 32'(failed), 32'h0);
      checkOutput("rst_cnt", 32'(realign_cnt), 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Full sweep, every aligner answers 20 clocks after release.
      $display("[TB] sweep of all 24 channels");
      for (int i = 0; i < NVFAT; i++) expect_rst(i);
      expect_done(24'hFFFFFF, 24'h0, 16'h0);
      applyStimulus(24'h0, 1'b0);
      checkOutput("lat_busy_edge0", 32'(busy), 32'h0);
      @(negedge clock);
      checkOutput("lat_busy_edge1", 32'(busy), 32'h1);
      checkOutput("lat_reset_edge1", 32'(aligner_reset), 32'h0);
      @(negedge clock);
      checkOutput("lat_reset_edge2", 32'(aligner_reset), 32'h1);
      wait_done(3000, "sweep");

      // Channel 5 never aligns: four attempts, then failed.
      $display("[TB] channel 5 exhausts retries");
      never[5] = 1'b1;
      for (int i = 0; i < 5; i++) expect_rst(i);
      for (int r = 0; r <= MR; r++) expect_rst(5);
      for (int i = 6; i < NVFAT; i++) expect_rst(i);
      expect_done(24'hFFFFDF, 24'h000020, 16'h0);
      applyStimulus(24'h0, 1'b0);
      wait_done(5000, "retry");
      never[5] = 1'b0;

      // Mask 4..7 right after start: their pending bits must survive.
      $display("[TB] masked channels keep pending");
      for (int i = 0; i < 4; i++) expect_rst(i);
      for (int i = 8; i < NVFAT; i++) expect_rst(i);
      expect_done(24'hFFFFDF, 24'h0, 16'h0);
      applyStimulus(24'h0, 1'b0);
      vfat_mask = 24'h0000F0;
      wait_done(3000, "mask");
      repeat (20) @(negedge clock);
      checkOutput("mask_idle_busy", 32'(busy), 32'h0);
      for (int i = 4; i < 8; i++) expect_rst(i);
      expect_done(24'hFFFFFF, 24'h0, 16'h0);
      vfat_mask = 24'h0;
      wait_done(1000, "unmask");

      // Unstable edge on channel 9 with and without auto re-queue.
      $display("[TB] unstable re-queue");
      auto_realign = 1'b1;
      expect_rst(9);
      expect_done(24'hFFFFFF, 24'h0, 16'h1);
      sot_unstable[9] = 1'b1;
      @(posedge clock); #1;
      checkOutput("unstable_aligned9_drop", 32'(aligned[9]), 32'h0);
      checkOutput("unstable_cnt1", 32'(realign_cnt), 32'h1);
      wait_done(500, "requeue");
      sot_unstable[9] = 1'b0;
      auto_realign    = 1'b0;
      repeat (3) @(negedge clock);
      sot_unstable[9] = 1'b1;
      @(posedge clock); #1;
      checkOutput("noauto_aligned9_drop", 32'(aligned[9]), 32'h0);
      repeat (40) @(negedge clock);
      checkOutput("noauto_busy", 32'(busy), 32'h0);
      checkOutput("noauto_cnt", 32'(realign_cnt), 32'h1);
      sot_unstable[9] = 1'b0;
      repeat (2) @(negedge clock);

      // Asynchronous reset while waiting on channel 12 (pointer resumes at 10).
      $display("[TB] reset during wait");
      expect_rst(10); expect_rst(11); expect_rst(12);
      applyStimulus(24'h0, 1'b0);
      n = 0;
      while (!aligner_reset[12] && n < 500) begin @(negedge clock); n++; end
      while (aligner_reset[12] && n < 500) begin @(negedge clock); n++; end
      checkOutput("reach_wait12", 32'(n < 500), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_aligner_reset", 32'(aligner_reset), 32'h0);
      checkOutput("async_busy", 32'(busy), 32'h0);
      checkOutput("async_active", 32'(active_vfat), 32'h0);
      checkOutput("async_aligned", 32'(aligned), 32'h0);
      checkOutput("async_failed", 32'(failed), 32'h0);
      checkOutput("async_cnt", 32'(realign_cnt), 32'h0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (30) @(negedge clock);
      checkOutput("post_reset_busy", 32'(busy), 32'h0);
      checkOutput("post_reset_aligner", 32'(aligner_reset), 32'h0);
      checkOutput("post_reset_queue", 32'(sbq.size()), 32'h0);

      // Success on the very clock the timeout expires: aligned, no retry.
      $display("[TB] success ties with timeout");
      lat[0] = TO;
      expect_rst(0);
      expect_done(24'h000001, 24'h0, 16'h0);
      applyStimulus(24'hFFFFFE, 1'b0);
      wait_done(500, "tie");
      lat[0] = 20;

      // Drive the re-queue counter into saturation.
      $display("[TB] realign counter saturation");
      sb_quiet     = 1'b1;
      vfat_mask    = 24'h0;
      auto_realign = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock); sot_unstable = '1;
         @(negedge clock); sot_unstable = '0;
      end
      checkOutput("cnt_saturated", 32'(realign_cnt), 32'hFFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); sot_unstable = '1;
         @(negedge clock); sot_unstable = '0;
      end
      checkOutput("cnt_stays_saturated", 32'(realign_cnt), 32'hFFFF);
      auto_realign = 1'b0;
      n = 0;
      while (busy && n < 5000) begin @(negedge clock); n++; end
      checkOutput("drain_idle", 32'(busy), 32'h0);
      @(negedge clock);
      sb_quiet = 1'b0;
      checkOutput("final_queue", 32'(sbq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
